micro_sequencer: RTL and testbench

- Microprogrammed control unit for the multicycle RV32 core.
- Owns the 4-bit micro-PC register and the 11-entry control store. It drives every datapath control strike each cycle.
- It computes the next micro-address internally: sequential, dispatch ROM 1, dispatch ROM 2, fetch, or the ALU-writeback state.
- It adds a memory ready/stall handshake and an illegal-opcode trap on top of that sequencing.

---
 rtl/micro_sequencer.sv | 146 ++++++++++++++
 tb/tb_micro_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit for the multicycle RV32 core: owns the micro-PC,
// the 11-entry control store, next-address selection, memory stall and illegal-op trap.
module micro_sequencer #(
    parameter logic [3:0] TRAP_ADDR = 4'hF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] upc,
    output logic       mem_req,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_ALUWB  = 4'd7,
        S_EXECI  = 4'd8,
        S_JAL    = 4'd9,
        S_BEQ    = 4'd10,
        S_TRAP   = TRAP_ADDR
    } state_e;

    typedef enum logic [2:0] {NX_SEQ, NX_D1, NX_D2, NX_FETCH, NX_WB, NX_TRAP} nxt_e;

    typedef struct packed {
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] aluop;
        logic [1:0] result;
        logic       adr_src;
        logic       ir_write;
        logic       pcupd;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       mem;
        nxt_e       nxt;
    } ctrl_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;

    state_e state, state_n;
    ctrl_t  cw;
    logic   gate;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state   <= state_n;
            illegal <= illegal | (state_n == S_TRAP);
        end
    end

    // Control store; anything not listed (trap and encodings 11-14) is all-zero and traps.
    always_comb begin
        cw     = '0;
        cw.nxt = NX_TRAP;
        case (state)
            S_FETCH:  begin cw.result = 2'b10; cw.src_b = 2'b10; cw.ir_write = 1'b1;
                            cw.pcupd = 1'b1; cw.mem = 1'b1; cw.nxt = NX_SEQ; end
            S_DECODE: begin cw.src_a = 2'b01; cw.src_b = 2'b01; cw.nxt = NX_D1; end
            S_MEMADR: begin cw.src_a = 2'b10; cw.src_b = 2'b01; cw.nxt = NX_D2; end
            S_MEMRD:  begin cw.adr_src = 1'b1; cw.mem = 1'b1; cw.nxt = NX_SEQ; end
            S_MEMWB:  begin cw.result = 2'b01; cw.reg_write = 1'b1; cw.nxt = NX_FETCH; end
            S_MEMWR:  begin cw.adr_src = 1'b1; cw.mem_write = 1'b1; cw.mem = 1'b1;
                            cw.nxt = NX_FETCH; end
            S_EXECR:  begin cw.src_a = 2'b10; cw.aluop = 2'b10; cw.nxt = NX_SEQ; end
            S_ALUWB:  begin cw.reg_write = 1'b1; cw.nxt = NX_FETCH; end
            S_EXECI:  begin cw.src_a = 2'b10; cw.src_b = 2'b01; cw.aluop = 2'b10; cw.nxt = NX_WB; end
            S_JAL:    begin cw.src_a = 2'b01; cw.src_b = 2'b10; cw.pcupd = 1'b1; cw.nxt = NX_WB; end
            S_BEQ:    begin cw.src_a = 2'b10; cw.aluop = 2'b01; cw.branch = 1'b1; cw.nxt = NX_FETCH; end
            default:  ;
        endcase
    end

    // Memory states stall until mem_ready; non-memory states never wait.
    assign gate = !cw.mem || mem_ready;

    always_comb begin
        state_n = state;
        case (cw.nxt)
            NX_SEQ:   state_n = state_e'(state + 4'd1);
            NX_D1: begin
                case (op)
                    OP_R:         state_n = S_EXECR;
                    OP_I:         state_n = S_EXECI;
                    OP_JAL:       state_n = S_JAL;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    default:      state_n = S_TRAP;
                endcase
            end
            NX_D2: begin
                case (op)
                    OP_LW:   state_n = S_MEMRD;
                    OP_SW:   state_n = S_MEMWR;
                    default: state_n = S_TRAP;
                endcase
            end
            NX_FETCH: state_n = S_FETCH;
            NX_WB:    state_n = S_ALUWB;
            default:  state_n = S_TRAP;
        endcase
        if (!gate) state_n = state;
    end

    // Strobes are masked by reset_n so an async reset kills any in-flight write at once.
    assign upc        = state;
    assign mem_req    = reset_n & cw.mem;
    assign ir_write   = reset_n & gate & cw.ir_write;
    assign mem_write  = reset_n & gate & cw.mem_write;
    assign reg_write  = reset_n & cw.reg_write;
    assign pc_write   = reset_n & ((gate & cw.pcupd) | (cw.branch & zero));
    assign adr_src    = cw.adr_src;
    assign result_src = cw.result;
    assign alu_src_a  = cw.src_a;
    assign alu_src_b  = cw.src_b;
    assign alu_op     = cw.aluop;
    assign instr_done = reset_n & gate & (cw.nxt == NX_FETCH);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed table-driven bench for micro_sequencer, plus hand sequences for trap
// persistence and asynchronous reset during a memory write.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [3:0] upc;
    logic       mem_req, ir_write, mem_write, reg_write, pc_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal, instr_done;

    micro_sequencer dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .upc(upc), .mem_req(mem_req), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .pc_write(pc_write), .adr_src(adr_src),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal(illegal), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // {mem_req, ir_write, mem_write, reg_write, pc_write, adr_src, instr_done, illegal}
    wire [7:0] stb = {mem_req, ir_write, mem_write, reg_write, pc_write, adr_src, instr_done, illegal};
    // {result_src, alu_src_a, alu_src_b, alu_op}
    wire [7:0] sel = {result_src, alu_src_a, alu_src_b, alu_op};

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       z;
        logic       mr;
        logic [3:0] upc;
        logic [7:0] stb;
        logic [7:0] sel;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, J = 7'b1101111;
    localparam logic [6:0] B = 7'b1100011, L = 7'b0000011, S = 7'b0100011, X = 7'b1110011;

    // Expected per-state output patterns
    localparam logic [7:0] ST_F  = 8'b1100_1000, ST_FW = 8'b1000_0000, ST_0 = 8'b0000_0000;
    localparam logic [7:0] ST_MR = 8'b1000_0100, ST_WB = 8'b0001_0010;
    localparam logic [7:0] ST_MW = 8'b1010_0110, ST_BT = 8'b0000_1010, ST_BN = 8'b0000_0010;
    localparam logic [7:0] ST_J  = 8'b0000_1000, ST_TR = 8'b0000_0001;
    localparam logic [7:0] SL_0 = 8'b10_00_10_00, SL_1 = 8'b00_01_01_00, SL_2 = 8'b00_10_01_00;
    localparam logic [7:0] SL_4 = 8'b01_00_00_00, SL_6 = 8'b00_10_00_10, SL_8 = 8'b00_10_01_10;
    localparam logic [7:0] SL_9 = 8'b00_01_10_00, SL_A = 8'b00_10_00_01, SL_Z = 8'b00_00_00_00;

    function automatic vec_t mk(logic rst, logic [6:0] o, logic z, logic mr,
                                logic [3:0] u, logic [7:0] s, logic [7:0] l);
        vec_t v;
        v.rst = rst; v.op = o; v.z = z; v.mr = mr; v.upc = u; v.stb = s; v.sel = l;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; op = R; zero = 1'b0; mem_ready = 1'b1;

        tbl.push_back(mk(0, R, 0, 1, 4'd0, ST_0, SL_0));   // in reset: strobes forced off
        // R-type, mem_ready low in non-memory states is ignored
        tbl.push_back(mk(1, R, 0, 1, 4'd0, ST_F, SL_0));
        tbl.push_back(mk(1, R, 0, 0, 4'd1, ST_0, SL_1));
        tbl.push_back(mk(1, R, 0, 0, 4'd6, ST_0, SL_6));
        tbl.push_back(mk(1, R, 0, 1, 4'd7, ST_WB, SL_Z));
        // lw with 2 wait cycles in fetch and 3 in read; op garbage in state 3 is ignored
        tbl.push_back(mk(1, L, 0, 0, 4'd0, ST_FW, SL_0));
        tbl.push_back(mk(1, L, 0, 0, 4'd0, ST_FW, SL_0));
        tbl.push_back(mk(1, L, 0, 1, 4'd0, ST_F, SL_0));
        tbl.push_back(mk(1, L, 0, 1, 4'd1, ST_0, SL_1));
        tbl.push_back(mk(1, L, 0, 1, 4'd2, ST_0, SL_2));
        tbl.push_back(mk(1, X, 0, 0, 4'd3, ST_MR, SL_Z));
        tbl.push_back(mk(1, L, 0, 0, 4'd3, ST_MR, SL_Z));
        tbl.push_back(mk(1, L, 0, 0, 4'd3, ST_MR, SL_Z));
        tbl.push_back(mk(1, X, 0, 1, 4'd3, ST_MR, SL_Z));
        tbl.push_back(mk(1, L, 0, 1, 4'd4, ST_WB, SL_4));
        // sw with one write wait
        tbl.push_back(mk(1, S, 0, 1, 4'd0, ST_F, SL_0));
        tbl.push_back(mk(1, S, 0, 1, 4'd1, ST_0, SL_1));
        tbl.push_back(mk(1, S, 0, 1, 4'd2, ST_0, SL_2));
        tbl.push_back(mk(1, S, 0, 0, 4'd5, ST_MR, SL_Z));
        tbl.push_back(mk(1, S, 0, 1, 4'd5, ST_MW, SL_Z));
        // beq taken, then not taken
        tbl.push_back(mk(1, B, 0, 1, 4'd0, ST_F, SL_0));
        tbl.push_back(mk(1, B, 0, 1, 4'd1, ST_0, SL_1));
        tbl.push_back(mk(1, B, 1, 1, 4'd10, ST_BT, SL_A));
        tbl.push_back(mk(1, B, 0, 1, 4'd0, ST_F, SL_0));
        tbl.push_back(mk(1, B, 0, 1, 4'd1, ST_0, SL_1));
        tbl.push_back(mk(1, B, 0, 1, 4'd10, ST_BN, SL_A));
        // jal, then I-type
        tbl.push_back(mk(1, J, 0, 1, 4'd0, ST_F, SL_0));
        tbl.push_back(mk(1, J, 0, 1, 4'd1, ST_0, SL_1));
        tbl.push_back(mk(1, J, 0, 1, 4'd9, ST_J, SL_9));
        tbl.push_back(mk(1, J, 0, 1, 4'd7, ST_WB, SL_Z));
        tbl.push_back(mk(1, I, 0, 1, 4'd0, ST_F, SL_0));
        tbl.push_back(mk(1, I, 0, 1, 4'd1, ST_0, SL_1));
        tbl.push_back(mk(1, I, 0, 1, 4'd8, ST_0, SL_8));
        tbl.push_back(mk(1, I, 0, 1, 4'd7, ST_WB, SL_Z));
        // illegal opcode traps
        tbl.push_back(mk(1, X, 0, 1, 4'd0, ST_F, SL_0));
        tbl.push_back(mk(1, X, 1, 1, 4'd1, ST_0, SL_1));
        tbl.push_back(mk(1, R, 1, 1, 4'd15, ST_TR, SL_Z));

        foreach (tbl[k]) begin
            @(negedge clk);
            reset_n = tbl[k].rst; op = tbl[k].op; zero = tbl[k].z; mem_ready = tbl[k].mr;
            #1;
            chk("upc", k, {4'd0, upc}, {4'd0, tbl[k].upc});
            chk("strobes", k, stb, tbl[k].stb);
            chk("selects", k, sel, tbl[k].sel);
        end

        // Trap is sticky regardless of inputs
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            op = L; zero = i[0]; mem_ready = ~i[1];
            #1;
            chk("trap_upc", i, {4'd0, upc}, 8'h0F);
            chk("trap_strobes", i, stb, ST_TR);
        end

        // Async reset clears trap mid-cycle
        #1 reset_n = 1'b0;
        #1;
        chk("trap_rst_upc", 0, {4'd0, upc}, 8'h00);
        chk("trap_rst_strobes", 0, stb, ST_0);
        chk("trap_rst_selects", 0, sel, SL_0);

        // Async reset while writing in state 5
        @(negedge clk);
        reset_n = 1'b1; op = S; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("sw_upc", 1, {4'd0, upc}, 8'h05);
        chk("sw_strobes", 1, stb, ST_MW);
        #1 reset_n = 1'b0;
        #1;
        chk("async_mem_write", 1, {7'd0, mem_write}, 8'h00);
        chk("async_upc", 1, {4'd0, upc}, 8'h00);
        chk("async_strobes", 1, stb, ST_0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
